mult_8x8_seq: RTL and testbench
===============================

// Module: mult_8x8_seq
// PURPOSE
//  Sequential 8x8 unsigned multiplier built around one shared 4x4 multiplier.
//  Four partial products are shifted and accumulated into a 16-bit product,
//  with a done flag on completion. A 7-segment digit shows the controller
//  state. Standalone datapath block driven by a start pulse.
// PARAMETERS
//  None. Widths are fixed: 8-bit operands, 4x4->8 core, 16-bit product.
// PORTS
//  clk        in   1   clock; all registers update on the rising edge
//  reset_a    in   1   reset; synchronous, active-high
//  start      in   1   begin multiply; sampled on clk edges
//  dataa      in   8   unsigned operand A; captured on an accepted start
//  datab      in   8   unsigned operand B; captured on an accepted start
//  done_flag  out  1   registered; 1 while the result is final (DONE state)
//  product8   out  16  registered accumulator; equals A*B when done_flag=1
//  seg_a..seg_g out 1 each  7-seg state display; active-high by default
// BEHAVIOUR
//  Reset (reset_a=1 at an edge; overrides start):
//  - state=IDLE, cnt=0, A/B regs=0, product8=0, done_flag=0, display "0".
//  States:
//  - IDLE: start=1 captures dataa/datab, clears product8, goes to CALC with cnt=0.
//  - CALC: 4 cycles, cnt=0..3. Each edge adds pp(cnt) to product8 and increments
//    cnt. At cnt=3 it goes to DONE.
//  - DONE: sets done_flag=1 and holds product8. start=1 recaptures the operands,
//    clears product8 and done_flag, and goes to CALC with cnt=0. Otherwise it stays.
//  Partial products (one shared 4x4 core, operands muxed by cnt, 16-bit add):
//  - cnt0: A[3:0]*B[3:0] << 0
//  - cnt1: A[7:4]*B[3:0] << 4
//  - cnt2: A[3:0]*B[7:4] << 4
//  - cnt3: A[7:4]*B[7:4] << 8
//  - The sum never exceeds 16 bits (max 255*255=0xFE01); no overflow handling.
//  Latency:
//  - start accepted at edge N -> done_flag=1 and final product8 after edge N+4.
//  - Intermediate product8 values during CALC are partial sums; they are valid
//    only when done_flag=1.
//  - start during CALC is ignored.
//  - Operand changes after capture have no effect.
//  - reset_a mid-CALC aborts to the reset values on that edge.
//  Display (decoded from registered state; segs = {a,b,c,d,e,f,g}, 1=lit):
//  - IDLE "0"  = 1111110
//  - CALC cnt0 "1" = 0110000
//  - CALC cnt1 "2" = 1101101
//  - CALC cnt2 "3" = 1111001
//  - CALC cnt3 "4" = 0110011
//  - DONE "d"  = 0111101
// CONFIGURATION
//  SEG_ACTIVE_LOW_EN
//  - Defined: all seven seg outputs are inverted (common-anode display).
//    Reset display "0" = 0000001.
//  - Undefined: outputs are active-high as listed above.
//  - Arithmetic, done_flag and timing are identical in both builds.
// TESTING
//  1. reset_a=1 for 2 edges -> product8=0, done_flag=0, segs=1111110.
//  2. A=255, B=255, start one cycle -> after 4 more edges: product8=0xFE01
//     (65025), done_flag=1, segs "d".
//  3. From DONE: A=10, B=30, start one cycle -> done_flag drops on the next
//     edge; after 4 more: product8=0x012C (300), done_flag=1.
//  4. A=0, B=0xAB -> product8=0. Also check A=0x0F,B=0xF0 -> 0x0E10 and
//     A=0xF0,B=0x0F -> 0x0E10 (exercises cnt1/cnt2).
//  5. Start, then start pulsed again during CALC and dataa changed -> result
//     unaffected; done at edge N+4.
//  6. reset_a=1 at cnt2 -> next edge IDLE, product8=0, done_flag=0. Repeat
//     case 2 with SEG_ACTIVE_LOW_EN defined -> segs inverted, same product.

Source files
------------

// File: rtl/mult_8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 core, four partial products accumulated over four cycles.
// Optional build macro SEG_ACTIVE_LOW_EN inverts the seven-segment state display for common-anode parts.
module mult_8x8_seq (
   input  logic        clk,
   input  logic        reset_a,
   input  logic        start,
   input  logic [7:0]  dataa,
   input  logic [7:0]  datab,
   output logic        done_flag,
   output logic [15:0] product8,
   output logic        seg_a,
   output logic        seg_b,
   output logic        seg_c,
   output logic        seg_d,
   output logic        seg_e,
   output logic        seg_f,
   output logic        seg_g
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_reg;
   logic [1:0]  cnt_reg;
   logic [7:0]  a_reg;
   logic [7:0]  b_reg;

   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic [7:0]  core_prod;
   logic [15:0] pp;
   logic [6:0]  seg_hi;
   logic [6:0]  seg_out;

   // cnt bit 0 selects the A nibble, bit 1 the B nibble; the shift is the sum of the nibble weights.
   always_comb begin
      nib_a     = cnt_reg[0] ? a_reg[7:4] : a_reg[3:0];
      nib_b     = cnt_reg[1] ? b_reg[7:4] : b_reg[3:0];
      core_prod = {4'h0, nib_a} * {4'h0, nib_b};
      case (cnt_reg)
         2'd0:    pp = {8'h00, core_prod};
         2'd1,
         2'd2:    pp = {4'h0, core_prod, 4'h0};
         default: pp = {core_prod, 8'h00};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_a) begin
         state_reg <= IDLE;
         cnt_reg   <= 2'd0;
         a_reg     <= 8'h00;
         b_reg     <= 8'h00;
         product8  <= 16'h0000;
         done_flag <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg     <= dataa;
                  b_reg     <= datab;
                  product8  <= 16'h0000;
                  cnt_reg   <= 2'd0;
                  state_reg <= CALC;
               end
            end
            CALC: begin
               product8 <= product8 + pp;
               cnt_reg  <= cnt_reg + 2'd1;
               if (cnt_reg == 2'd3) begin
                  state_reg <= DONE;
                  done_flag <= 1'b1;
               end
            end
            DONE: begin
               if (start) begin
                  a_reg     <= dataa;
                  b_reg     <= datab;
                  product8  <= 16'h0000;
                  done_flag <= 1'b0;
                  cnt_reg   <= 2'd0;
                  state_reg <= CALC;
               end
            end
            default: begin
               state_reg <= IDLE;
               cnt_reg   <= 2'd0;
               done_flag <= 1'b0;
            end
         endcase
      end
   end

   // Display digit: "0" idle, "1".."4" for the CALC step, "d" when done.
   always_comb begin
      case (state_reg)
         IDLE: seg_hi = 7'b1111110;
         CALC: begin
            case (cnt_reg)
               2'd0:    seg_hi = 7'b0110000;
               2'd1:    seg_hi = 7'b1101101;
               2'd2:    seg_hi = 7'b1111001;
               default: seg_hi = 7'b0110011;
            endcase
         end
         DONE:    seg_hi = 7'b0111101;
         default: seg_hi = 7'b1111110;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_seg
`ifdef SEG_ACTIVE_LOW_EN
         assign seg_out[gi] = ~seg_hi[gi];
`else
         assign seg_out[gi] = seg_hi[gi];
`endif
      end
   endgenerate

   assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_out;

endmodule

// File: tb/tb_mult_8x8_seq.sv
// Self-checking bench for mult_8x8_seq: directed corner cases plus random operands against plain a*b.
// Display expectations follow the SEG_ACTIVE_LOW_EN build setting.
module tb_mult_8x8_seq;

   logic        clk;
   logic        reset_a;
   logic        start;
   logic [7:0]  dataa;
   logic [7:0]  datab;
   logic        done_flag;
   logic [15:0] product8;
   logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
   logic [6:0]  segs;

   int vectors     = 0;
   int miscompares = 0;

   mult_8x8_seq dut (
      .clk       (clk),
      .reset_a   (reset_a),
      .start     (start),
      .dataa     (dataa),
      .datab     (datab),
      .done_flag (done_flag),
      .product8  (product8),
      .seg_a     (seg_a),
      .seg_b     (seg_b),
      .seg_c     (seg_c),
      .seg_d     (seg_d),
      .seg_e     (seg_e),
      .seg_f     (seg_f),
      .seg_g     (seg_g)
   );

   assign segs = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digit shown for a phase: 0 idle, 1..4 calc steps, 5 done.
   function automatic logic [6:0] exp_seg(input int phase);
      logic [6:0] v;
      case (phase)
         0:       v = 7'b1111110;
         1:       v = 7'b0110000;
         2:       v = 7'b1101101;
         3:       v = 7'b1111001;
         4:       v = 7'b0110011;
         default: v = 7'b0111101;
      endcase
`ifdef SEG_ACTIVE_LOW_EN
      v = ~v;
`endif
      return v;
   endfunction

   function automatic logic [34:0] exp_seg_hist();
      logic [34:0] h;
      for (int k = 0; k < 5; k++) h[k*7 +: 7] = exp_seg(k + 1);
      return h;
   endfunction

   // Pulses start with the given operands and records outputs after each of the next five edges.
   // With disturb set, start is re-pulsed mid-calculation and the operand inputs are scrambled.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit disturb,
                         output logic [15:0] prod, output logic [4:0] done_hist,
                         output logic [34:0] seg_hist);
      @(negedge clk);
      dataa = a;
      datab = b;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         done_hist[k]       = done_flag;
         seg_hist[k*7 +: 7] = segs;
         if (disturb && k == 1) begin
            start = 1'b1;
            dataa = ~a;
            datab = b ^ 8'h5A;
         end else begin
            start = 1'b0;
         end
      end
      prod = product8;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset_a = 1'b1;
      start   = 1'b1;
      dataa   = 8'h12;
      datab   = 8'h34;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (product8 !== 16'h0000 || done_flag !== 1'b0 || segs !== exp_seg(0)) begin
         miscompares++;
         $display("FAIL reset: product8=%h done=%b segs=%b required 0000 0 %b",
                  product8, done_flag, segs, exp_seg(0));
      end
      reset_a = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (product8 !== 16'h0000 || done_flag !== 1'b0 || segs !== exp_seg(0)) begin
         miscompares++;
         $display("FAIL idle_hold: product8=%h done=%b segs=%b", product8, done_flag, segs);
      end
      $display("reset: product8=%h done=%b segs=%b", product8, done_flag, segs);
   endtask

   task automatic test_directed();
      logic [7:0]  ta [6] = '{8'hFF, 8'h0A, 8'h00, 8'h0F, 8'hF0, 8'h01};
      logic [7:0]  tb [6] = '{8'hFF, 8'h1E, 8'hAB, 8'hF0, 8'h0F, 8'h80};
      logic [15:0] p;
      logic [4:0]  dh;
      logic [34:0] sh;
      logic [15:0] expv;
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], tb[i], 1'b0, p, dh, sh);
         expv = 16'(ta[i]) * 16'(tb[i]);
         vectors++;
         if (p !== expv) begin
            miscompares++;
            $display("FAIL directed_product: %h*%h got %h required %h", ta[i], tb[i], p, expv);
         end
         vectors++;
         if (dh !== 5'b10000) begin
            miscompares++;
            $display("FAIL directed_done: %h*%h done history %b required 10000", ta[i], tb[i], dh);
         end
         vectors++;
         if (sh !== exp_seg_hist()) begin
            miscompares++;
            $display("FAIL directed_segs: %h*%h segs history %h required %h", ta[i], tb[i], sh, exp_seg_hist());
         end
         $display("directed: %h*%h -> %h done_hist=%b", ta[i], tb[i], p, dh);
      end
      // DONE must hold its result while start stays low.
      repeat (3) @(negedge clk);
      vectors++;
      if (product8 !== 16'h0080 || done_flag !== 1'b1 || segs !== exp_seg(5)) begin
         miscompares++;
         $display("FAIL done_hold: product8=%h done=%b segs=%b required 0080 1 %b",
                  product8, done_flag, segs, exp_seg(5));
      end
   endtask

   task automatic test_start_during_calc();
      logic [15:0] p;
      logic [4:0]  dh;
      logic [34:0] sh;
      run_op(8'hC3, 8'h7E, 1'b1, p, dh, sh);
      vectors++;
      if (p !== 16'(8'hC3) * 16'(8'h7E) || dh !== 5'b10000) begin
         miscompares++;
         $display("FAIL start_in_calc: product %h done_hist %b required %h 10000",
                  p, dh, 16'(8'hC3) * 16'(8'h7E));
      end
      $display("start_in_calc: C3*7E -> %h done_hist=%b", p, dh);
   endtask

   task automatic test_back_to_back();
      logic [15:0] p;
      logic [4:0]  dh;
      logic [34:0] sh;
      logic [7:0]  a;
      logic [7:0]  b;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         run_op(a, b, (i % 4) == 3, p, dh, sh);
         vectors++;
         if (p !== 16'(a) * 16'(b) || dh !== 5'b10000 || sh !== exp_seg_hist()) begin
            miscompares++;
            $display("FAIL random: %h*%h got %h done_hist %b segs %h required %h 10000 %h",
                     a, b, p, dh, sh, 16'(a) * 16'(b), exp_seg_hist());
         end
         $display("random: %h*%h -> %h", a, b, p);
      end
   endtask

   task automatic test_reset_mid_calc();
      @(negedge clk);
      dataa = 8'h9D;
      datab = 8'h44;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (segs !== exp_seg(3)) begin
         miscompares++;
         $display("FAIL pre_abort_segs: segs=%b required %b", segs, exp_seg(3));
      end
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0;
      vectors++;
      if (product8 !== 16'h0000 || done_flag !== 1'b0 || segs !== exp_seg(0)) begin
         miscompares++;
         $display("FAIL reset_mid_calc: product8=%h done=%b segs=%b required 0000 0 %b",
                  product8, done_flag, segs, exp_seg(0));
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (product8 !== 16'h0000 || done_flag !== 1'b0 || segs !== exp_seg(0)) begin
         miscompares++;
         $display("FAIL post_abort_idle: product8=%h done=%b segs=%b", product8, done_flag, segs);
      end
      $display("reset_mid_calc: product8=%h done=%b segs=%b", product8, done_flag, segs);
   endtask

   initial begin
      reset_a = 1'b1;
      start   = 1'b0;
      dataa   = 8'h00;
      datab   = 8'h00;
      test_reset();
      test_directed();
      test_start_during_calc();
      test_back_to_back();
      test_reset_mid_calc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
